// File: rtl/afe_parameters_pkg.sv
// Shared types and per-RX tagging constants for the AFE receive sample taggers.
package afe_parameters_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HOLD  = 2'd2,
      GAP   = 2'd3
   } afe_tag_state_e;

   localparam int AFE_NUM_RX = 2;

   // Index i of every array describes RX instance i.
   localparam int AFE_TAG_CHID_LSB    [AFE_NUM_RX] = '{16, 16};
   localparam int AFE_TAG_FLAG_LSB    [AFE_NUM_RX] = '{20, 20};
   localparam int AFE_TAG_HOLD_CYCLES [AFE_NUM_RX] = '{4, 4};
   localparam int AFE_TAG_GAP_CYCLES  [AFE_NUM_RX] = '{4, 4};

   function automatic int afe_max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/afe_rx_sample_tagger_if.sv
// Sample-in / slow-valid-out bus of the AFE receive sample tagger.
interface afe_rx_sample_tagger_if #(
   parameter int NUM_CHS    = 4,
   parameter int PL_WIDTH   = 16,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_CHS-1:0]               sample_valid_i;
   logic [NUM_CHS-1:0][PL_WIDTH-1:0] sample_data_i;
   logic                             afe_valid_o;
   logic [DATA_WIDTH-1:0]            afe_data_o;

   modport master (
      output sample_valid_i,
      output sample_data_i,
      input  afe_valid_o,
      input  afe_data_o
   );

   modport slave (
      input  sample_valid_i,
      input  sample_data_i,
      output afe_valid_o,
      output afe_data_o
   );
endinterface

// File: rtl/afe_rx_tag_fifo.sv
// Small synchronous FIFO for tagged words; full/empty come from the registered count,
// so a pop never frees room for a push in the same cycle.
module afe_rx_tag_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        push_ok_s, pop_ok_s;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      full_o     = (count_q == CW'(DEPTH));
      empty_o    = (count_q == CW'(0));
      push_ok_s  = push_i && !full_o;
      pop_ok_s   = pop_i && !empty_o;
      pop_data_o = mem_q[rd_q];
      mem_d      = mem_q;
      if (push_ok_s) begin
         mem_d[wr_q] = push_data_i;
         wr_d        = wr_q + AW'(1);
      end else begin
         wr_d        = wr_q;
      end
      if (pop_ok_s) begin
         rd_d = rd_q + AW'(1);
      end else begin
         rd_d = rd_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q   <= {DEPTH{{WIDTH{1'b0}}}};
         wr_q    <= AW'(0);
         rd_q    <= AW'(0);
         count_q <= CW'(0);
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/afe_rx_sample_tagger.sv
// Captures per-channel ADC samples, tags them with channel ID and threshold flag,
// and replays them one at a time on a slow valid/data pair sized for an async synchroniser.
module afe_rx_sample_tagger
   import afe_parameters_pkg::*;
#(
   parameter int NUM_CHS     = 4,
   parameter int PL_WIDTH    = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int CHID_LSB    = AFE_TAG_CHID_LSB[0],
   parameter int CHID_WIDTH  = 4,
   parameter int FLAG_LSB    = AFE_TAG_FLAG_LSB[0],
   parameter int HOLD_CYCLES = AFE_TAG_HOLD_CYCLES[0],
   parameter int GAP_CYCLES  = AFE_TAG_GAP_CYCLES[0],
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic [PL_WIDTH-1:0] thresh_i,
   input  logic                clr_i,
   output logic [15:0]         drop_cnt_o,
   output logic                overflow_o,
   afe_rx_sample_tagger_if.slave bus
);
   localparam int CH_W = $clog2(NUM_CHS);
   localparam int PH_W = $clog2(afe_max_int(HOLD_CYCLES, GAP_CYCLES) + 1);

   logic [NUM_CHS-1:0]               pend_q, pend_d;
   logic [NUM_CHS-1:0][PL_WIDTH-1:0] pdat_q, pdat_d;
   logic [NUM_CHS-1:0]               gnt_s, drop_s;
   logic [CH_W-1:0]                  rr_q, rr_d, gnt_idx_s;
   logic                             gnt_vld_s, found_s;
   logic [DATA_WIDTH-1:0]            word_s, fifo_rdata_s;
   logic                             fifo_full_s, fifo_empty_s, pop_s;
   logic [15:0]                      drop_cnt_q, drop_cnt_d;
   logic                             ovf_q, ovf_d;
   afe_tag_state_e                   state_q, state_d;
   logic [PH_W-1:0]                  phase_q, phase_d;
   logic [DATA_WIDTH-1:0]            data_q, data_d;
   logic                             valid_q, valid_d;
   int                               idx_s;

   function automatic logic [DATA_WIDTH-1:0] build_word(
      input logic [PL_WIDTH-1:0] sample,
      input logic [CH_W-1:0]     chid,
      input logic                flag
   );
      logic [DATA_WIDTH-1:0] w;
      w                          = {DATA_WIDTH{1'b0}};
      w[PL_WIDTH-1:0]            = sample;
      w[CHID_LSB +: CHID_WIDTH]  = CHID_WIDTH'(chid);
      w[FLAG_LSB]                = flag;
      return w;
   endfunction

   // Round-robin search starting at rr_q; a grant needs room in the FIFO.
   always_comb begin
      found_s   = 1'b0;
      gnt_idx_s = CH_W'(0);
      idx_s     = 0;
      for (int k = 0; k < NUM_CHS; k++) begin
         idx_s = int'(rr_q) + k;
         if (idx_s >= NUM_CHS) begin
            idx_s = idx_s - NUM_CHS;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && pend_q[CH_W'(idx_s)]) begin
            found_s   = 1'b1;
            gnt_idx_s = CH_W'(idx_s);
         end else begin
            found_s   = found_s;
         end
      end
      gnt_vld_s          = found_s && !fifo_full_s;
      gnt_s              = {NUM_CHS{1'b0}};
      gnt_s[gnt_idx_s]   = gnt_vld_s;
      word_s             = build_word(pdat_q[gnt_idx_s], gnt_idx_s,
                                      (pdat_q[gnt_idx_s] >= thresh_i));
      if (gnt_vld_s) begin
         rr_d = (gnt_idx_s == CH_W'(NUM_CHS - 1)) ? CH_W'(0) : gnt_idx_s + CH_W'(1);
      end else begin
         rr_d = rr_q;
      end
   end

   // Capture into pending slots; a slot being granted this cycle can take a new sample.
   always_comb begin
      pend_d = pend_q;
      pdat_d = pdat_q;
      drop_s = {NUM_CHS{1'b0}};
      for (int c = 0; c < NUM_CHS; c++) begin
         drop_s[c] = bus.sample_valid_i[c] && en_i && pend_q[c] && !gnt_s[c];
         if (bus.sample_valid_i[c] && en_i && (!pend_q[c] || gnt_s[c])) begin
            pend_d[c] = 1'b1;
            pdat_d[c] = bus.sample_data_i[c];
         end else if (gnt_s[c]) begin
            pend_d[c] = 1'b0;
         end else begin
            pend_d[c] = pend_q[c];
         end
      end
   end

   // Drop statistics; a drop coinciding with clear counts as the first new drop.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      ovf_d      = ovf_q;
      if (|drop_s) begin
         ovf_d = 1'b1;
         if (clr_i) begin
            drop_cnt_d = 16'd1;
         end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
      end else if (clr_i) begin
         drop_cnt_d = 16'd0;
         ovf_d      = 1'b0;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   afe_rx_tag_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (gnt_vld_s),
      .push_data_i (word_s),
      .pop_i       (pop_s),
      .pop_data_o  (fifo_rdata_s),
      .full_o      (fifo_full_s),
      .empty_o     (fifo_empty_s)
   );

   // Output sequencer: data loads only on IDLE->SETUP and stays put until the next load.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      data_d  = data_q;
      valid_d = 1'b0;
      pop_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               data_d  = fifo_rdata_s;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d = HOLD;
            phase_d = PH_W'(0);
            valid_d = 1'b1;
         end
         HOLD: begin
            if (phase_q == PH_W'(HOLD_CYCLES - 1)) begin
               state_d = GAP;
               phase_d = PH_W'(0);
               valid_d = 1'b0;
            end else begin
               phase_d = phase_q + PH_W'(1);
               valid_d = 1'b1;
            end
         end
         GAP: begin
            if (phase_q == PH_W'(GAP_CYCLES - 1)) begin
               state_d = IDLE;
               phase_d = PH_W'(0);
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = PH_W'(0);
         end
      endcase
   end

   // State registers for capture, arbitration, statistics and output sequencer.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pend_q     <= {NUM_CHS{1'b0}};
         pdat_q     <= {NUM_CHS{{PL_WIDTH{1'b0}}}};
         rr_q       <= CH_W'(0);
         drop_cnt_q <= 16'd0;
         ovf_q      <= 1'b0;
         state_q    <= IDLE;
         phase_q    <= PH_W'(0);
         data_q     <= {DATA_WIDTH{1'b0}};
         valid_q    <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pdat_q     <= pdat_d;
         rr_q       <= rr_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_q      <= ovf_d;
         state_q    <= state_d;
         phase_q    <= phase_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.afe_valid_o = valid_q;
   assign bus.afe_data_o  = data_q;
   assign drop_cnt_o      = drop_cnt_q;
   assign overflow_o      = ovf_q;
endmodule

// File: tb/tb_afe_rx_sample_tagger.sv
// Directed bench for afe_rx_sample_tagger: expected words, timings and drop counts are hand-derived.
module tb_afe_rx_sample_tagger;
   localparam int GAP_CYC = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i  = 1'b0;
   logic        clr_i = 1'b0;
   logic [15:0] thresh_i = 16'h0000;
   logic [15:0] drop_cnt_o;
   logic        overflow_o;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int stable_err = 0;
   logic [31:0] words[$];
   int          rise_cyc[$];
   int          lens[$];
   logic        setup_ok[$];

   afe_rx_sample_tagger_if #(.NUM_CHS(4), .PL_WIDTH(16), .DATA_WIDTH(32)) bus ();

   afe_rx_sample_tagger #(
      .NUM_CHS(4), .PL_WIDTH(16), .DATA_WIDTH(32), .CHID_LSB(16), .CHID_WIDTH(4),
      .FLAG_LSB(20), .HOLD_CYCLES(4), .GAP_CYCLES(4), .FIFO_DEPTH(4)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .thresh_i   (thresh_i),
      .clr_i      (clr_i),
      .drop_cnt_o (drop_cnt_o),
      .overflow_o (overflow_o),
      .bus        (bus)
   );

   initial forever #5 clk_i = ~clk_i;
   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   // Word monitor: records each rising valid, its high length, and data stability.
   initial begin : monitor
      logic        pv;
      logic [31:0] pd, lat;
      int          hl, gl;
      pv = 1'b0; pd = 32'd0; lat = 32'd0; hl = 0; gl = 0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            pv = 1'b0; gl = 0; hl = 0;
         end else begin
            if (bus.afe_valid_o && !pv) begin
               words.push_back(bus.afe_data_o);
               rise_cyc.push_back(cyc);
               setup_ok.push_back(bus.afe_data_o === pd);
               lat = bus.afe_data_o;
               hl  = 1;
            end else if (bus.afe_valid_o) begin
               hl++;
               if (bus.afe_data_o !== lat) stable_err++;
            end else if (pv) begin
               lens.push_back(hl);
               gl = GAP_CYC - 1;
               if (bus.afe_data_o !== lat) stable_err++;
            end else if (gl > 0) begin
               gl--;
               if (bus.afe_data_o !== lat) stable_err++;
            end
            pv = bus.afe_valid_o;
            pd = bus.afe_data_o;
         end
      end
   end

   function automatic logic [31:0] wd(input int i);
      return (i < words.size()) ? words[i] : 32'hxxxx_xxxx;
   endfunction
   function automatic int rc(input int i);
      return (i < rise_cyc.size()) ? rise_cyc[i] : -1000;
   endfunction
   function automatic int ln(input int i);
      return (i < lens.size()) ? lens[i] : -1;
   endfunction
   function automatic logic so(input int i);
      return (i < setup_ok.size()) ? setup_ok[i] : 1'bx;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic apply_reset();
      bus.sample_valid_i = 4'b0000;
      rst_i = 1'b1;
      tick(3);
      rst_i = 1'b0;
      tick(2);
   endtask

   logic [31:0] exp2 [4] = '{32'h0000_0001, 32'h0001_0002, 32'h0002_0003, 32'h0003_0004};
   logic [31:0] exp4 [9] = '{32'h0000_0100, 32'h0001_0101, 32'h0002_0102, 32'h0003_0103,
                             32'h0010_0200, 32'h0011_0301, 32'h0012_0402, 32'h0013_0403,
                             32'h0010_0400};

   initial begin
      int b, s;
      bus.sample_valid_i = 4'b0000;
      bus.sample_data_i  = '0;
      tick(3);
      check("rst_valid", 32'(bus.afe_valid_o), 32'd0);
      check("rst_data", bus.afe_data_o, 32'd0);
      check("rst_cnt", 32'(drop_cnt_o), 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      rst_i = 1'b0;
      en_i  = 1'b1;
      tick(2);

      // Single sample on ch2 above threshold.
      b = words.size();
      thresh_i = 16'h1000;
      bus.sample_data_i[2] = 16'h1234;
      bus.sample_valid_i = 4'b0100;
      s = cyc;
      tick(1);
      bus.sample_valid_i = 4'b0000;
      tick(24);
      check("t1_count", 32'(words.size() - b), 32'd1);
      check("t1_word", wd(b), 32'h0012_1234);
      check("t1_latency", 32'(rc(b) - s), 32'd4);
      check("t1_hold", 32'(ln(b)), 32'd4);
      check("t1_setup", 32'(so(b)), 32'd1);
      check("t1_stable", 32'(stable_err), 32'd0);

      // All four channels at once, below threshold.
      apply_reset();
      b = words.size();
      thresh_i = 16'hFFFF;
      for (int c = 0; c < 4; c++) bus.sample_data_i[c] = 16'(c + 1);
      bus.sample_valid_i = 4'b1111;
      tick(1);
      bus.sample_valid_i = 4'b0000;
      tick(45);
      check("t2_count", 32'(words.size() - b), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t2_word%0d", i), wd(b + i), exp2[i]);
         check($sformatf("t2_hold%0d", i), 32'(ln(b + i)), 32'd4);
      end
      for (int i = 0; i < 3; i++)
         check($sformatf("t2_period%0d", i), 32'(rc(b + i + 1) - rc(b + i)), 32'd10);
      check("t2_stable", 32'(stable_err), 32'd0);

      // Capture disabled: no words, no drops.
      b = words.size();
      en_i = 1'b0;
      bus.sample_data_i[0] = 16'hAAAA;
      bus.sample_valid_i = 4'b0001;
      tick(3);
      bus.sample_valid_i = 4'b0000;
      tick(20);
      check("t2b_nowords", 32'(words.size() - b), 32'd0);
      check("t2b_cnt", 32'(drop_cnt_o), 32'd0);
      check("t2b_pend", 32'(dut.pend_q), 32'd0);
      en_i = 1'b1;

      // ch1 strobed every cycle for 20 cycles.
      apply_reset();
      thresh_i = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         bus.sample_data_i[1] = 16'(i);
         bus.sample_valid_i = 4'b0010;
         tick(1);
      end
      check("t3_cnt", 32'(drop_cnt_o), 32'd13);
      check("t3_ovf", 32'(overflow_o), 32'd1);
      clr_i = 1'b1;
      tick(1);
      check("t3_clr_drop_cnt", 32'(drop_cnt_o), 32'd1);
      check("t3_clr_drop_ovf", 32'(overflow_o), 32'd1);
      bus.sample_valid_i = 4'b0000;
      tick(1);
      check("t3_clr_cnt", 32'(drop_cnt_o), 32'd0);
      check("t3_clr_ovf", 32'(overflow_o), 32'd0);
      clr_i = 1'b0;

      // Three back-to-back rounds on all channels fill FIFO and pending slots.
      apply_reset();
      b = words.size();
      thresh_i = 16'h0200;
      for (int r = 1; r <= 3; r++) begin
         for (int c = 0; c < 4; c++) bus.sample_data_i[c] = 16'((r << 8) | c);
         bus.sample_valid_i = 4'b1111;
         tick(1);
      end
      bus.sample_valid_i = 4'b0000;
      check("t4_cnt_a", 32'(drop_cnt_o), 32'd2);
      tick(4);
      check("t4_fifo_full", 32'(dut.u_fifo.count_q), 32'd4);
      check("t4_pend", 32'(dut.pend_q), 32'h2);
      for (int c = 0; c < 4; c++) bus.sample_data_i[c] = 16'((4 << 8) | c);
      bus.sample_valid_i = 4'b1111;
      tick(2);
      bus.sample_valid_i = 4'b0000;
      check("t4_cnt_b", 32'(drop_cnt_o), 32'd4);
      tick(110);
      check("t4_count", 32'(words.size() - b), 32'd9);
      for (int i = 0; i < 9; i++)
         check($sformatf("t4_word%0d", i), wd(b + i), exp4[i]);

      // Saturation of the drop counter.
      apply_reset();
      bus.sample_valid_i = 4'b1111;
      tick(65540);
      check("t5_sat", 32'(drop_cnt_o), 32'h0000_FFFF);
      check("t5_ovf", 32'(overflow_o), 32'd1);
      tick(5);
      check("t5_sat_hold", 32'(drop_cnt_o), 32'h0000_FFFF);
      bus.sample_valid_i = 4'b0000;

      // Reset in the middle of HOLD.
      apply_reset();
      thresh_i = 16'h0000;
      bus.sample_data_i[0] = 16'h5555;
      bus.sample_valid_i = 4'b0001;
      tick(1);
      bus.sample_valid_i = 4'b0000;
      for (int i = 0; i < 20 && !bus.afe_valid_o; i++) tick(1);
      check("t6_in_hold", 32'(bus.afe_valid_o), 32'd1);
      tick(1);
      #2 rst_i = 1'b1;
      #1;
      check("t6_async_valid", 32'(bus.afe_valid_o), 32'd0);
      check("t6_async_data", bus.afe_data_o, 32'd0);
      check("t6_fifo_empty", 32'(dut.u_fifo.count_q), 32'd0);
      check("t6_rr", 32'(dut.rr_q), 32'd0);
      tick(2);
      rst_i = 1'b0;
      b = words.size();
      tick(30);
      check("t6_no_word", 32'(words.size() - b), 32'd0);
      check("t6_valid_low", 32'(bus.afe_valid_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
